// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the D-stage decode/pipeline registers and hazard_ctrl.
// The master side drives operand/destination info; the slave (controller) drives enables and MDU status.
interface hazard_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [4:0]       rs_D;
  logic [4:0]       rt_D;
  logic [1:0]       tuse_rs_D;
  logic [1:0]       tuse_rt_D;
  logic             md_D;
  logic [4:0]       dst_E;
  logic [1:0]       tnew_E;
  logic [4:0]       dst_M;
  logic [1:0]       tnew_M;
  logic             start_E;
  logic             div_E;
  logic             pc_en;
  logic             fd_en;
  logic             de_clr;
  logic             md_busy;
  logic [CNT_W-1:0] busy_cnt;
  logic [31:0]      stall_cnt;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
    output dst_E, tnew_E, dst_M, tnew_M, start_E, div_E,
    input  pc_en, fd_en, de_clr, md_busy, busy_cnt, stall_cnt
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
    input  dst_E, tnew_E, dst_M, tnew_M, start_E, div_E,
    output pc_en, fd_en, de_clr, md_busy, busy_cnt, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: Tuse/Tnew data hazards plus
// an MDU occupancy countdown decide PC/F2D enables and the D2E bubble.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             stall_rs, stall_rt, stall_md;
  logic             md_busy_raw;
  logic             stall;

  // Tuse of 3 can never be below a Tnew (max 2), so unread operands drop out naturally.
  always_comb begin
    stall_rs = (hz.rs_D != 5'd0) &&
               (((hz.rs_D == hz.dst_E) && (hz.tuse_rs_D < hz.tnew_E)) ||
                ((hz.rs_D == hz.dst_M) && (hz.tuse_rs_D < hz.tnew_M)));
    stall_rt = (hz.rt_D != 5'd0) &&
               (((hz.rt_D == hz.dst_E) && (hz.tuse_rt_D < hz.tnew_E)) ||
                ((hz.rt_D == hz.dst_M) && (hz.tuse_rt_D < hz.tnew_M)));
  end

  always_comb begin
    md_busy_raw = hz.start_E || (busy_cnt_q != '0);
    stall_md    = hz.md_D && md_busy_raw;
    stall       = !reset && (stall_rs || stall_rt || stall_md);
  end

  always_comb begin
    hz.pc_en     = !stall;
    hz.fd_en     = !stall;
    hz.de_clr    = stall;
    hz.md_busy   = !reset && md_busy_raw;
    hz.busy_cnt  = busy_cnt_q;
    hz.stall_cnt = stall_cnt_q;
  end

  // A new start reloads even mid-countdown: the E instruction always advances.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (hz.start_E) begin
      busy_cnt_d = hz.div_E ? DIV_LOAD : MULT_LOAD;
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change just after each falling edge and
// outputs are checked 1 time unit later, so every step is one pipeline cycle.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   cmpCount;
  int   failCount;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hzIf ();

  hazard_ctrl #(
    .MULT_CYC(5),
    .DIV_CYC (10),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hzIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(
    input logic       rst,
    input logic [4:0] rs, input logic [1:0] tuseRs,
    input logic [4:0] rt, input logic [1:0] tuseRt,
    input logic       md,
    input logic [4:0] dstE, input logic [1:0] tnewE,
    input logic [4:0] dstM, input logic [1:0] tnewM,
    input logic       start, input logic div
  );
    @(negedge clk);
    reset          = rst;
    hzIf.rs_D      = rs;
    hzIf.tuse_rs_D = tuseRs;
    hzIf.rt_D      = rt;
    hzIf.tuse_rt_D = tuseRt;
    hzIf.md_D      = md;
    hzIf.dst_E     = dstE;
    hzIf.tnew_E    = tnewE;
    hzIf.dst_M     = dstM;
    hzIf.tnew_M    = tnewM;
    hzIf.start_E   = start;
    hzIf.div_E     = div;
    #1;
  endtask

  task automatic idle(input logic md);
    applyStimulus(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, md, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    cmpCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStall(input string tag, input logic s);
    checkOutput({tag, ".pc_en"},  32'(hzIf.pc_en),  32'(!s));
    checkOutput({tag, ".fd_en"},  32'(hzIf.fd_en),  32'(!s));
    checkOutput({tag, ".de_clr"}, 32'(hzIf.de_clr), 32'(s));
  endtask

  task automatic checkState(input string tag, input logic busy, input int cnt, input logic [31:0] stalls);
    checkOutput({tag, ".md_busy"},   32'(hzIf.md_busy),  32'(busy));
    checkOutput({tag, ".busy_cnt"},  32'(hzIf.busy_cnt), 32'(cnt));
    checkOutput({tag, ".stall_cnt"}, hzIf.stall_cnt,     stalls);
  endtask

  initial begin
    cmpCount  = 0;
    failCount = 0;
    reset     = 1'b1;
    hzIf.rs_D = '0; hzIf.tuse_rs_D = 2'd3; hzIf.rt_D = '0; hzIf.tuse_rt_D = 2'd3;
    hzIf.md_D = 1'b0; hzIf.dst_E = '0; hzIf.tnew_E = '0; hzIf.dst_M = '0; hzIf.tnew_M = '0;
    hzIf.start_E = 1'b0; hzIf.div_E = 1'b0;
    $display("[TB] start");

    // Reset held with a load-use hazard and MDU start present: outputs forced idle.
    applyStimulus(1'b1, 5'd5, 2'd0, 5'd0, 2'd3, 1'b1, 5'd5, 2'd2, 5'd0, 2'd0, 1'b1, 1'b1);
    checkStall("rst", 1'b0);
    checkState("rst", 1'b0, 0, 32'd0);
    idle(1'b0);
    checkStall("idle", 1'b0);
    checkState("idle", 1'b0, 0, 32'd0);

    // Load-use through E, then M, then released.
    applyStimulus(1'b0, 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    checkStall("lu_e", 1'b1);
    applyStimulus(1'b0, 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0, 1'b0);
    checkStall("lu_m", 1'b1);
    checkOutput("lu_m.stall_cnt", hzIf.stall_cnt, 32'd1);
    applyStimulus(1'b0, 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd5, 2'd0, 1'b0, 1'b0);
    checkStall("lu_rel", 1'b0);
    checkOutput("lu_rel.stall_cnt", hzIf.stall_cnt, 32'd2);

    // Register 0, unread rt, rt hazard, and Tuse == Tnew boundary.
    applyStimulus(1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    checkStall("r0", 1'b0);
    applyStimulus(1'b0, 5'd0, 2'd3, 5'd7, 2'd3, 1'b0, 5'd7, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    checkStall("rt_nouse", 1'b0);
    applyStimulus(1'b0, 5'd0, 2'd3, 5'd7, 2'd1, 1'b0, 5'd7, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    checkStall("rt_haz", 1'b1);
    applyStimulus(1'b0, 5'd0, 2'd3, 5'd7, 2'd2, 1'b0, 5'd7, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    checkStall("rt_eq", 1'b0);
    checkOutput("rt_eq.stall_cnt", hzIf.stall_cnt, 32'd3);

    // mult then mfhi: busy t..t+5, counter 5..1, released at t+6.
    applyStimulus(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
    checkStall("mul_t", 1'b1);
    checkState("mul_t", 1'b1, 0, 32'd3);
    for (int i = 1; i <= 5; i++) begin
      idle(1'b1);
      checkStall("mul_run", 1'b1);
      checkState("mul_run", 1'b1, 6 - i, 32'(3 + i));
    end
    idle(1'b1);
    checkStall("mul_rel", 1'b0);
    checkState("mul_rel", 1'b0, 0, 32'd9);

    // div then mflo: counter 10..1, md_D stalls through t+10.
    applyStimulus(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    checkStall("div_t", 1'b1);
    for (int i = 1; i <= 10; i++) begin
      idle(1'b1);
      checkStall("div_run", 1'b1);
      checkState("div_run", 1'b1, 11 - i, 32'(9 + i));
    end
    idle(1'b1);
    checkStall("div_rel", 1'b0);
    checkState("div_rel", 1'b0, 0, 32'd20);

    // Reset mid-div when busy_cnt reads 6.
    applyStimulus(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    checkState("rdiv_t", 1'b1, 0, 32'd20);
    for (int i = 1; i <= 4; i++) idle(1'b0);
    checkOutput("rdiv_7.busy_cnt", 32'(hzIf.busy_cnt), 32'd7);
    applyStimulus(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    checkStall("rdiv_rst", 1'b0);
    checkState("rdiv_rst", 1'b0, 6, 32'd20);
    idle(1'b1);
    checkStall("rdiv_after", 1'b0);
    checkState("rdiv_after", 1'b0, 0, 32'd0);

    // Restart at busy_cnt=3, then data hazard plus MDU stall counted once.
    applyStimulus(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) idle(1'b0);
    checkOutput("rs_4.busy_cnt", 32'(hzIf.busy_cnt), 32'd4);
    applyStimulus(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    checkState("rs_re", 1'b1, 3, 32'd0);
    applyStimulus(1'b0, 5'd5, 2'd0, 5'd0, 2'd3, 1'b1, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
    checkStall("both", 1'b1);
    checkState("both", 1'b1, 10, 32'd0);
    idle(1'b0);
    checkStall("both_after", 1'b0);
    checkState("both_after", 1'b1, 9, 32'd1);

    // Saturation: preload near max, then stall across the limit.
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    #1;
    checkOutput("sat_pre", hzIf.stall_cnt, 32'hFFFF_FFFD);
    applyStimulus(1'b0, 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    checkStall("sat_stall", 1'b1);
    applyStimulus(1'b0, 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("sat_fe", hzIf.stall_cnt, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("sat_ff", hzIf.stall_cnt, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("sat_hold", hzIf.stall_cnt, 32'hFFFF_FFFF);
    idle(1'b0);
    checkOutput("sat_idle", hzIf.stall_cnt, 32'hFFFF_FFFF);
    checkStall("sat_idle", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
